// File: rtl/svc_axil_rd_arbiter.sv
// Round-robin arbiter merging NUM_M AXI-Lite read subordinates onto one manager port.
// Grant order is kept in a route FIFO so in-order R beats steer back to their requester.
module svc_axil_rd_arbiter #(
  parameter int NUM_M             = 2,
  parameter int ADDR_WIDTH        = 8,
  parameter int DATA_WIDTH        = 16,
  parameter int OUTSTANDING_WIDTH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_M-1:0]            s_axil_arvalid,
  input  logic [NUM_M*ADDR_WIDTH-1:0] s_axil_araddr,
  output logic [NUM_M-1:0]            s_axil_arready,
  output logic [NUM_M-1:0]            s_axil_rvalid,
  output logic [DATA_WIDTH-1:0]       s_axil_rdata,
  output logic [1:0]                  s_axil_rresp,
  input  logic [NUM_M-1:0]            s_axil_rready,
  output logic                        m_axil_arvalid,
  output logic [ADDR_WIDTH-1:0]       m_axil_araddr,
  input  logic                        m_axil_arready,
  input  logic                        m_axil_rvalid,
  input  logic [DATA_WIDTH-1:0]       m_axil_rdata,
  input  logic [1:0]                  m_axil_rresp,
  output logic                        m_axil_rready
);

  localparam int IdxW  = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int Depth = 1 << OUTSTANDING_WIDTH;

  logic                         ar_valid_q;
  logic [ADDR_WIDTH-1:0]        ar_addr_q;
  logic [IdxW-1:0]              last_grant_q;
  logic [IdxW-1:0]              route_mem [Depth];
  logic [OUTSTANDING_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [OUTSTANDING_WIDTH:0]   count_q, count_d;

  logic            ar_free, fifo_full, fifo_ne, can_grant, found, pop;
  logic [IdxW-1:0] winner, head;
  int              cand;

  assign ar_free   = !ar_valid_q || m_axil_arready;
  assign fifo_full = (count_q == (OUTSTANDING_WIDTH + 1)'(Depth));
  assign fifo_ne   = (count_q != '0);
  assign can_grant = ar_free && !fifo_full && (|s_axil_arvalid);
  assign head      = route_mem[rd_ptr_q];

  // Scan starting just after the previous winner so every requester gets a turn.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = 0;
    for (int k = 1; k <= NUM_M; k++) begin
      cand = (int'(last_grant_q) + k) % NUM_M;
      if (!found && s_axil_arvalid[cand[IdxW-1:0]]) begin
        found  = 1'b1;
        winner = cand[IdxW-1:0];
      end
    end
  end

  assign s_axil_arready = can_grant ? (NUM_M'(1) << winner) : '0;
  assign m_axil_arvalid = ar_valid_q;
  assign m_axil_araddr  = ar_addr_q;

  assign m_axil_rready  = fifo_ne && s_axil_rready[head];
  assign s_axil_rvalid  = (m_axil_rvalid && fifo_ne) ? (NUM_M'(1) << head) : '0;
  assign s_axil_rdata   = m_axil_rdata;
  assign s_axil_rresp   = m_axil_rresp;
  assign pop            = m_axil_rvalid && m_axil_rready;

  always_comb begin
    count_d = count_q;
    if (can_grant && !pop) begin
      count_d = count_q + (OUTSTANDING_WIDTH + 1)'(1);
    end else if (pop && !can_grant) begin
      count_d = count_q - (OUTSTANDING_WIDTH + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ar_valid_q   <= 1'b0;
      ar_addr_q    <= '0;
      last_grant_q <= IdxW'(NUM_M - 1);
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      if (can_grant) begin
        ar_valid_q   <= 1'b1;
        ar_addr_q    <= s_axil_araddr[winner*ADDR_WIDTH +: ADDR_WIDTH];
        last_grant_q <= winner;
        wr_ptr_q     <= wr_ptr_q + OUTSTANDING_WIDTH'(1);
      end else if (m_axil_arready) begin
        ar_valid_q <= 1'b0;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + OUTSTANDING_WIDTH'(1);
      end
      count_q <= count_d;
    end
  end

  // Storage only; validity is tracked by count_q, so no reset is needed.
  always_ff @(posedge clk) begin
    if (can_grant) begin
      route_mem[wr_ptr_q] <= winner;
    end
  end

endmodule

// File: doc/svc_axil_rd_arbiter.md
Name: svc_axil_rd_arbiter

Overview:
- Round-robin arbiter sharing one AXI-Lite read manager port among NUM_M AXI-Lite read subordinate ports.
- Sits between several read clients (e.g. ID-reflect bridges, cache fill engines) and a single memory/peripheral read port.
- Issues one registered AR per grant and records the grant index in an in-order route FIFO; R beats are steered back by the FIFO head.
- Supports up to 2^OUTSTANDING_WIDTH reads in flight.

Parameters:
- NUM_M, 2, number of requesting subordinate ports (2..8).
- ADDR_WIDTH, 8, read address width.
- DATA_WIDTH, 16, read data width.
- OUTSTANDING_WIDTH, 2, log2 of the route FIFO depth (maximum reads in flight).

Ports:
- clk  input  1  single clock; one clock domain, all logic on rising edge.
- rst  input  1  reset; synchronous, active-high.
- s_axil_arvalid  input  NUM_M  per-port AR valid.
- s_axil_araddr  input  NUM_M*ADDR_WIDTH  per-port AR address, flattened; port i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- s_axil_arready  output  NUM_M  per-port AR ready.
- s_axil_rvalid  output  NUM_M  per-port R valid.
- s_axil_rdata  output  DATA_WIDTH  R data, broadcast to all ports.
- s_axil_rresp  output  2  R response, broadcast to all ports.
- s_axil_rready  input  NUM_M  per-port R ready.
- m_axil_arvalid  output  1  AR valid to downstream.
- m_axil_araddr  output  ADDR_WIDTH  AR address to downstream.
- m_axil_arready  input  1  AR ready from downstream.
- m_axil_rvalid  input  1  R valid from downstream.
- m_axil_rdata  input  DATA_WIDTH  R data from downstream.
- m_axil_rresp  input  2  R response from downstream.
- m_axil_rready  output  1  R ready to downstream.

Behaviour:
- Reset (rst=1 at a clock edge):
  - m_axil_arvalid=0, m_axil_araddr=0.
  - Route FIFO empty.
  - last_grant=NUM_M-1, so port 0 has highest priority on the first arbitration.
  - Consequently all s_axil_arready=0, all s_axil_rvalid=0, m_axil_rready=0.
  - Reset mid-operation discards all in-flight routing. Downstream must be reset together with this block.
- AR slot free: ar_free = !m_axil_arvalid || m_axil_arready.
- AR can_grant: ar_free && route FIFO not full && any s_axil_arvalid.
- Winner selection: first asserted arvalid scanning from last_grant+1 upward, wrapping modulo NUM_M.
- s_axil_arready:
  - s_axil_arready[i] = can_grant && (i==winner). Combinational; ready may depend on valid.
  - At most one bit is set per cycle.
- On a grant handshake, next edge:
  - m_axil_arvalid<=1, m_axil_araddr<=winner's address.
  - Push winner index into the route FIFO.
  - last_grant<=winner.
  - AR latency: exactly 1 cycle, subordinate handshake to m_axil_arvalid.
- Downstream accept without a new grant: m_axil_arvalid<=0. m_axil_araddr holds its value.
- Back-to-back grants: when m_axil_arready=1, a new grant in the same cycle yields continuous arvalid, one AR per cycle.
- m_axil_arvalid stays high with stable address until m_axil_arready. A pending AR is never withdrawn.
- Full route FIFO: no grant, even if a pop occurs in the same cycle (pop-then-push is not bypassed). Grant resumes the cycle after the pop.
- R routing, with head = route FIFO head index and ne = FIFO non-empty:
  - s_axil_rvalid[i] = m_axil_rvalid && ne && (head==i).
  - m_axil_rready = ne && s_axil_rready[head].
  - s_axil_rdata and s_axil_rresp pass through combinationally, zero latency.
  - Pop on m_axil_rvalid && m_axil_rready.
- m_axil_rvalid while FIFO empty is a downstream protocol violation. m_axil_rready stays 0 and nothing is routed.
- Push and pop in the same cycle with FIFO not full: both take effect, occupancy unchanged.
- Responses return in grant order. Downstream must be in-order, which holds for AXI-Lite.
- Fairness: a continuously requesting port waits at most NUM_M-1 grants.

Test Plan:
- Single request: reset, port 1 arvalid, addr 0x24, m_arready=1.
  - s_arready[1]=1 in cycle 0; m_arvalid=1 with araddr=0x24 in cycle 1.
  - m_rvalid with rdata=0xBEEF, rresp=0 -> s_rvalid=2'b10, data 0xBEEF, pop.
- Round robin: NUM_M=2, both ports hold arvalid, addrs 0x10 and 0x20, m_arready=1.
  - Grants alternate 0,1,0,1; m_araddr sequence 0x10,0x20,0x10,0x20.
  - R beats route to ports 0,1,0,1 in order.
- Downstream stall: m_arready=0 for 3 cycles after a grant.
  - m_arvalid and araddr stay stable; all s_arready=0.
  - On the next accept cycle a new grant occurs and m_arvalid stays high.
- Full FIFO: OUTSTANDING_WIDTH=2, 4 grants with no R.
  - 5th request sees s_arready=0.
  - One R handshake pops; the grant occurs on the following cycle.
- R backpressure: head port 0 holds rready=0 while m_rvalid=1.
  - m_rready=0, s_rvalid[0]=1, s_rvalid[1]=0.
  - Port 1 rready=1 has no effect.
- Reset mid-flight: 2 outstanding, then rst=1 for one cycle.
  - m_arvalid=0, FIFO empty.
  - Next request from port 0 wins first.
